// File: rtl/ft_sync_bus_ctrl_if.sv
// FT232H 245-sync bus plus TX FIFO read side and RX command sink.
// master = bus controller, slave = pads / FIFO / sink side.
interface ft_sync_bus_ctrl_if;
    logic       ft_rxf_i;
    logic       ft_txe_i;
    logic [7:0] ft_data_i;
    logic [7:0] ft_data_o;
    logic       ft_data_oe_o;
    logic       ft_rd_o;
    logic       ft_wr_o;
    logic       ft_oe_o;
    logic [7:0] tx_data_i;
    logic       tx_empty_i;
    logic       tx_rdreq_o;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       rx_full_i;

    modport master (
        input  ft_rxf_i, ft_txe_i, ft_data_i,
        input  tx_data_i, tx_empty_i, rx_full_i,
        output ft_data_o, ft_data_oe_o,
        output ft_rd_o, ft_wr_o, ft_oe_o,
        output tx_rdreq_o, rx_data_o, rx_valid_o
    );

    modport slave (
        output ft_rxf_i, ft_txe_i, ft_data_i,
        output tx_data_i, tx_empty_i, rx_full_i,
        input  ft_data_o, ft_data_oe_o,
        input  ft_rd_o, ft_wr_o, ft_oe_o,
        input  tx_rdreq_o, rx_data_o, rx_valid_o
    );
endinterface

// File: rtl/ft_sync_bus_ctrl.sv
// FT232H 245-sync FIFO bus owner: RX/TX arbitration, turnaround, bursts.
// Optional FT_STATS_EN adds byte counters and a sticky RX drop flag.
module ft_sync_bus_ctrl #(
    parameter int TX_BURST_MAX = 512,
    parameter int RX_BURST_MAX = 64,
    parameter int CNT_W        = 10
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                en_i,
    ft_sync_bus_ctrl_if.master  bus,
    output logic                busy_o
`ifdef FT_STATS_EN
    ,
    output logic [31:0]         tx_bytes_o,
    output logic [31:0]         rx_bytes_o,
    output logic                rx_drop_o
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        RX_OE,
        RX_RD,
        RX_END,
        TX_WR
    } state_t;

    localparam logic DIR_RX = 1'b0;
    localparam logic DIR_TX = 1'b1;

    localparam logic [CNT_W-1:0] TX_MAX = CNT_W'(TX_BURST_MAX);
    localparam logic [CNT_W-1:0] RX_MAX = CNT_W'(RX_BURST_MAX);

    state_t           state_q, state_d;
    logic             last_dir_q, last_dir_d;
    logic             rd_q, rd_d;
    logic [CNT_W-1:0] tx_cnt_q, rx_cnt_q;
    logic [CNT_W-1:0] tx_cnt_nxt, rx_cnt_nxt;
    logic [7:0]       rx_data_q;
    logic             rx_valid_q;

    logic rx_want, tx_want;
    logic tx_xfer, rx_xfer;
    logic rx_go;
    logic oe_n, data_oe, wr_n;

    assign rx_want = !bus.ft_rxf_i && !bus.rx_full_i;
    assign tx_want = !bus.ft_txe_i && !bus.tx_empty_i;

    // A TX byte moves whenever WR# is low; an RX byte whenever the
    // registered RD# is low and the host still has data.
    assign tx_xfer = (state_q == TX_WR) && tx_want;
    assign rx_xfer = (state_q == RX_RD) && !rd_q && !bus.ft_rxf_i;

    assign tx_cnt_nxt = tx_cnt_q + CNT_W'(tx_xfer);
    assign rx_cnt_nxt = rx_cnt_q + CNT_W'(rx_xfer);

    // Keep RD# low next cycle only if another byte may still be taken.
    assign rx_go = rx_want && (rx_cnt_nxt < RX_MAX);

    // Next state, round-robin grant and bus strobes.
    always_comb begin
        state_d    = state_q;
        last_dir_d = last_dir_q;
        rd_d       = 1'b1;
        oe_n       = 1'b1;
        data_oe    = 1'b1;
        wr_n       = 1'b1;
        unique case (state_q)
            IDLE: begin
                if (en_i) begin
                    if (rx_want && tx_want) begin
                        state_d = (last_dir_q == DIR_RX) ? TX_WR : RX_OE;
                    end else if (rx_want) begin
                        state_d = RX_OE;
                    end else if (tx_want) begin
                        state_d = TX_WR;
                    end
                end
            end
            RX_OE: begin
                oe_n    = 1'b0;
                data_oe = 1'b0;
                rd_d    = !rx_go;
                state_d = RX_RD;
            end
            RX_RD: begin
                oe_n    = 1'b0;
                data_oe = 1'b0;
                rd_d    = !rx_go;
                state_d = rx_go ? RX_RD : RX_END;
            end
            RX_END: begin
                data_oe    = 1'b0;
                last_dir_d = DIR_RX;
                state_d    = IDLE;
            end
            TX_WR: begin
                wr_n = !tx_want;
                if (!tx_want || (tx_cnt_nxt >= TX_MAX)) begin
                    last_dir_d = DIR_TX;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, direction history, RD# register and burst counters.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            last_dir_q <= DIR_RX;
            rd_q       <= 1'b1;
            tx_cnt_q   <= '0;
            rx_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            last_dir_q <= last_dir_d;
            rd_q       <= rd_d;
            tx_cnt_q   <= (state_q == TX_WR && state_d == TX_WR)
                          ? tx_cnt_nxt : '0;
            rx_cnt_q   <= (state_q == RX_RD) ? rx_cnt_nxt : '0;
        end
    end

    // Received byte is registered and flagged for exactly one cycle.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
        end else begin
            rx_valid_q <= rx_xfer;
            if (rx_xfer) begin
                rx_data_q <= bus.ft_data_i;
            end
        end
    end

    assign bus.ft_rd_o      = rd_q;
    assign bus.ft_wr_o      = wr_n;
    assign bus.ft_oe_o      = oe_n;
    assign bus.ft_data_oe_o = data_oe;
    assign bus.ft_data_o    = (state_q == TX_WR) ? bus.tx_data_i : 8'h00;
    assign bus.tx_rdreq_o   = !wr_n;
    assign bus.rx_data_o    = rx_data_q;
    assign bus.rx_valid_o   = rx_valid_q;
    assign busy_o           = (state_q != IDLE);

`ifdef FT_STATS_EN
    logic [7:0] drop_run_q;

    // Byte counters and detection of a host stalled by a full sink.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tx_bytes_o <= '0;
            rx_bytes_o <= '0;
            rx_drop_o  <= 1'b0;
            drop_run_q <= '0;
        end else begin
            if (tx_xfer) begin
                tx_bytes_o <= tx_bytes_o + 32'd1;
            end
            if (rx_xfer) begin
                rx_bytes_o <= rx_bytes_o + 32'd1;
            end
            if (state_q == IDLE && !bus.ft_rxf_i && bus.rx_full_i) begin
                if (drop_run_q == 8'hFF) begin
                    rx_drop_o <= 1'b1;
                end else begin
                    drop_run_q <= drop_run_q + 8'd1;
                end
            end else begin
                drop_run_q <= '0;
            end
        end
    end
`endif

endmodule

// File: doc/ft_sync_bus_ctrl.md
Name: ft_sync_bus_ctrl

Overview:
- Owns the FT232H 245-synchronous FIFO bus in the 60 MHz ft_shift_clk domain.
- Arbitrates the shared 8-bit bus between two directions:
  - TX: drains the async sample FIFO (show-ahead read side) to the host.
  - RX: receives host command bytes into a downstream command sink.
- Handles OE#/RD#/WR# sequencing, bus turnaround and burst-length fairness.
- Replaces ad-hoc WR# strobing at the top level.

Parameters:
- TX_BURST_MAX, 512: max bytes written per TX grant before RX is re-checked; must be ≥1.
- RX_BURST_MAX, 64: max bytes read per RX grant before TX is re-checked; must be ≥1.
- CNT_W, 10: width of the burst counters; must satisfy 2^CNT_W > max(TX_BURST_MAX, RX_BURST_MAX).

Ports:
- clk_i  in  1  ft_shift_clk, 60 MHz.
- rst_n_i  in  1  asynchronous active-low reset.
- en_i  in  1  controller enable; when low, no new grant is issued.
- ft_rxf_i  in  1  low = host data available.
- ft_txe_i  in  1  low = FT232H can accept data.
- ft_data_i  in  8  bus input path.
- ft_data_o  out  8  bus output path.
- ft_data_oe_o  out  1  high = FPGA drives bus (top-level tristate).
- ft_rd_o  out  1  RD#, active low.
- ft_wr_o  out  1  WR#, active low.
- ft_oe_o  out  1  OE#, active low.
- tx_data_i  in  8  show-ahead FIFO head byte.
- tx_empty_i  in  1  TX FIFO empty.
- tx_rdreq_o  out  1  pop TX FIFO.
- rx_data_o  out  8  received byte.
- rx_valid_o  out  1  one-cycle strobe for rx_data_o.
- rx_full_i  in  1  command sink cannot accept.
- busy_o  out  1  high whenever state != IDLE.

Behaviour:
- Reset values:
  - State IDLE.
  - ft_rd_o = 1, ft_wr_o = 1, ft_oe_o = 1, ft_data_oe_o = 1.
  - rx_valid_o = 0, rx_data_o = 0, tx_rdreq_o = 0, busy_o = 0, burst counters = 0.
  - Reset is asynchronous and may assert in any state: strobes deassert immediately; no byte is popped or emitted.
- States: IDLE, RX_OE, RX_RD, RX_END, TX_WR.
- IDLE:
  - ft_data_oe_o = 1, all strobes high.
  - If en_i = 0, stay in IDLE.
  - Arbitration order, with last_dir recording the previous grant:
    1. RX wants (!ft_rxf_i && !rx_full_i) and TX wants (!ft_txe_i && !tx_empty_i): grant the direction opposite to last_dir (round-robin).
    2. Only one wants: grant it.
    3. Neither wants: stay in IDLE.
  - Transitions: RX grant → RX_OE; TX grant → TX_WR.
- RX_OE (1 cycle):
  - ft_data_oe_o = 0, ft_oe_o = 0, ft_rd_o = 1 (turnaround).
  - Next state RX_RD.
- RX_RD:
  - ft_oe_o = 0, ft_data_oe_o = 0 throughout.
  - ft_rd_o is registered; it is low while the next-cycle condition holds: !ft_rxf_i && !rx_full_i && count < RX_BURST_MAX.
  - Byte transfer:
    - A byte transfers on each rising edge with ft_rd_o = 0 and ft_rxf_i = 0.
    - That byte is registered into rx_data_o, with rx_valid_o = 1 on the following cycle (1-cycle latency).
    - The RX counter increments on each transfer.
  - Exit to RX_END on any of: ft_rxf_i high, rx_full_i high, or count reaching RX_BURST_MAX.
  - Bytes sampled while ft_rxf_i = 1 are discarded.
- RX_END (1 cycle):
  - ft_rd_o = 1, ft_oe_o = 1, ft_data_oe_o stays 0 (turnaround).
  - Sets last_dir = RX; next state IDLE.
- TX_WR:
  - ft_data_oe_o = 1; ft_data_o = tx_data_i (combinational).
  - ft_wr_o = !(!tx_empty_i && !ft_txe_i) (combinational from state and inputs).
  - tx_rdreq_o is identical to the inverse of ft_wr_o: the FIFO is popped exactly on the edge a byte is accepted. No byte is lost or duplicated when ft_txe_i rises mid-burst.
  - The TX counter increments on each accepted byte.
  - Exit to IDLE (last_dir = TX, counter cleared) on any of: tx_empty_i, ft_txe_i high, or count reaching TX_BURST_MAX.
  - A transfer happening on the exit edge is counted once.
- Invariants:
  - ft_rd_o and ft_wr_o are never low in the same cycle.
  - ft_oe_o = 0 implies ft_data_oe_o = 0.
- en_i dropping mid-burst does not abort the burst; it only blocks the next grant.

Optional Feature:
- Macro: FT_STATS_EN.
- Defined:
  - Adds outputs tx_bytes_o[31:0] and rx_bytes_o[31:0].
  - Free-running counts of transferred bytes; wrap at 2^32; reset to 0.
  - Adds a sticky output rx_drop_o, set when ft_rxf_i is low in IDLE while rx_full_i is high for ≥256 consecutive cycles; cleared only by reset.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- TX only: FIFO holds 0x00..0x09, ft_txe_i = 0, ft_rxf_i = 1 → ten WR# low cycles, bus shows 0x00..0x09 in order, 10 pops, then IDLE.
- TX stall: ft_txe_i goes high after byte 0x03 is accepted, low again 5 cycles later → 0x04 is the next accepted byte; no duplicate, no skip; pop count equals accept count.
- RX burst: host presents 0xA5, 0x5A, 0x3C with ft_rxf_i low for 3 cycles → OE# low 1 cycle before RD#; rx_valid_o pulses 3 times with those bytes, 1 cycle after each transfer; RX_END turnaround precedes IDLE.
- Arbitration: both sides continuously ready, TX_BURST_MAX = 4, RX_BURST_MAX = 2 → grant sequence alternates TX(4)/RX(2)/TX(4); RD# and WR# are never simultaneously low.
- Backpressure: rx_full_i rises mid RX burst → RD# high on the next cycle, no rx_valid_o afterwards; no RX grant until rx_full_i falls.
- Reset mid-TX: assert rst_n_i low during a TX burst → WR# high, ft_data_oe_o = 1, tx_rdreq_o = 0 immediately; state IDLE after release.
